// File: rtl/folded_layer_pkg.sv
// Shared constants, FSM state encoding and the saturation helper for folded_layer.
package folded_layer_pkg;

  localparam int ACT_NONE  = 0;
  localparam int ACT_RELU  = 1;
  localparam int SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Clip a sign-extended value into a signed 'width'-bit range; ovf flags a clip.
  function automatic logic signed [SAT_MAX_W-1:0] sat(
    input  logic signed [SAT_MAX_W-1:0] val,
    input  int                          width,
    output logic                        ovf
  );
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (width - 1));
    ovf = 1'b0;
    if (val > hi) begin
      sat = hi;
      ovf = 1'b1;
    end else if (val < lo) begin
      sat = lo;
      ovf = 1'b1;
    end else begin
      sat = val;
    end
  endfunction

endpackage

// File: rtl/folded_layer_mac.sv
// One MAC lane: full-precision accumulator plus combinational finalize
// (bias add, floor shift, saturate, optional ReLU).
module mac_lane
  import folded_layer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 3,
  parameter int ACC_W     = 18,
  parameter int ACT_MODE  = 0
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_value,
  input  logic [WIDTH-1:0] i_weight,
  input  logic [WIDTH-1:0] i_bias,
  output logic [WIDTH-1:0] o_result,
  output logic             o_ovf
);

  logic signed [ACC_W-1:0]         r_acc;
  logic signed [2*WIDTH-1:0]       w_prod;
  logic signed [ACC_W:0]           w_bias_ext;
  logic signed [ACC_W:0]           w_sum;
  logic signed [ACC_W:0]           w_shift;
  logic signed [SAT_MAX_W-1:0]     w_wide;
  logic signed [SAT_MAX_W-1:0]     w_sat;
  logic        [SAT_MAX_W-WIDTH-1:0] w_unused_sat_hi;
  logic        [WIDTH-1:0]         w_sat_lo;
  logic                            w_ovf;

  assign w_prod = $signed(i_value) * $signed(i_weight);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

  // One guard bit above ACC_W so the bias add cannot wrap before saturation.
  always_comb begin
    w_bias_ext = (ACC_W+1)'($signed(i_bias));
    w_sum      = (ACC_W+1)'(r_acc) + (w_bias_ext <<< FRAC_BITS);
    w_shift    = w_sum >>> FRAC_BITS;
    w_wide     = SAT_MAX_W'(w_shift);
    w_ovf      = 1'b0;
    w_sat      = sat(w_wide, WIDTH, w_ovf);
  end

  assign {w_unused_sat_hi, w_sat_lo} = w_sat;

  always_comb begin
    o_result = w_sat_lo;
    if (ACT_MODE == ACT_RELU && w_sat_lo[WIDTH-1]) begin
      o_result = '0;
    end
  end

  assign o_ovf = w_ovf;

endmodule

// File: rtl/folded_layer.sv
// Time-multiplexed fully-connected layer: NUM_LANES MAC lanes sweep the
// NUM_OUTPUTS neurons group by group, with valid/ready on both sides.
//
// state    | meaning
// ST_IDLE  | READY_IN high, waiting for an input vector
// ST_MAC   | lanes accumulate one input term per cycle for group r_g
// ST_FINAL | lanes finalize, results written to output slots of group r_g
// ST_DONE  | VALID_OUT high, result held until READY_OUT
module folded_layer
  import folded_layer_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_OUTPUTS = 4,
  parameter int NUM_LANES   = 2,
  parameter int WIDTH       = 8,
  parameter int FRAC_BITS   = 3,
  parameter int ACT_MODE    = 0
) (
  input  logic                                CLK,
  input  logic                                RSTN,
  input  logic [NUM_INPUTS*WIDTH-1:0]         VALUES_IN,
  input  logic [NUM_OUTPUTS*NUM_INPUTS*WIDTH-1:0] WEIGHTS_IN,
  input  logic [NUM_OUTPUTS*WIDTH-1:0]        BIAS_IN,
  input  logic                                VALID_IN,
  output logic                                READY_IN,
  output logic [NUM_OUTPUTS*WIDTH-1:0]        VALUES_OUT,
  output logic                                VALID_OUT,
  input  logic                                READY_OUT,
  output logic                                OVERFLOW_OUT
);

  localparam int NUM_GROUPS = NUM_OUTPUTS / NUM_LANES;
  localparam int ACC_W      = 2*WIDTH + $clog2(NUM_INPUTS) + 1;
  localparam int I_W        = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int G_W        = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  if (NUM_OUTPUTS % NUM_LANES != 0) begin : g_bad_fold
    $error("folded_layer: NUM_OUTPUTS must be a multiple of NUM_LANES");
  end

  state_e                         r_state;
  state_e                         w_next;
  logic [I_W-1:0]                 r_i;
  logic [G_W-1:0]                 r_g;
  logic [NUM_INPUTS*WIDTH-1:0]    r_values;
  logic [NUM_OUTPUTS*WIDTH-1:0]   r_out;
  logic                           r_ovf;

  logic                           w_accept;
  logic                           w_mac_en;
  logic                           w_final;
  logic                           w_last_i;
  logic                           w_last_g;
  logic [WIDTH-1:0]               w_lane_res [NUM_LANES];
  logic [NUM_LANES-1:0]           w_lane_ovf;

  assign w_last_i = (r_i == I_W'(NUM_INPUTS - 1));
  assign w_last_g = (r_g == G_W'(NUM_GROUPS - 1));

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_mac_en = 1'b0;
    w_final  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (VALID_IN) begin
          w_accept = 1'b1;
          w_next   = ST_MAC;
        end
      end
      ST_MAC: begin
        w_mac_en = 1'b1;
        if (w_last_i) w_next = ST_FINAL;
      end
      ST_FINAL: begin
        w_final = 1'b1;
        w_next  = w_last_g ? ST_DONE : ST_MAC;
      end
      ST_DONE: begin
        if (READY_OUT) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_i      <= '0;
      r_g      <= '0;
      r_values <= '0;
      r_out    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_values <= VALUES_IN;
        r_i      <= '0;
        r_g      <= '0;
        r_ovf    <= 1'b0;
      end
      if (w_mac_en && !w_last_i) begin
        r_i <= r_i + 1'b1;
      end
      if (w_final) begin
        r_i   <= '0;
        r_ovf <= r_ovf | (|w_lane_ovf);
        for (int l = 0; l < NUM_LANES; l++) begin
          r_out[(int'(r_g)*NUM_LANES + l)*WIDTH +: WIDTH] <= w_lane_res[l];
        end
        if (!w_last_g) r_g <= r_g + 1'b1;
      end
    end
  end

  // Weights and biases are read live from the ports for the current group.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    mac_lane #(
      .WIDTH     (WIDTH),
      .FRAC_BITS (FRAC_BITS),
      .ACC_W     (ACC_W),
      .ACT_MODE  (ACT_MODE)
    ) u_lane (
      .CLK      (CLK),
      .RSTN     (RSTN),
      .i_clr    (w_accept | w_final),
      .i_en     (w_mac_en),
      .i_value  (r_values[int'(r_i)*WIDTH +: WIDTH]),
      .i_weight (WEIGHTS_IN[((int'(r_g)*NUM_LANES + l)*NUM_INPUTS + int'(r_i))*WIDTH +: WIDTH]),
      .i_bias   (BIAS_IN[(int'(r_g)*NUM_LANES + l)*WIDTH +: WIDTH]),
      .o_result (w_lane_res[l]),
      .o_ovf    (w_lane_ovf[l])
    );
  end

  assign READY_IN     = (r_state == ST_IDLE);
  assign VALID_OUT    = (r_state == ST_DONE);
  assign VALUES_OUT   = r_out;
  assign OVERFLOW_OUT = r_ovf;

endmodule

// File: tb/tb_folded_layer.sv
// Directed bench for folded_layer: identity and ReLU instances side by side,
// N=2, 4 outputs, 2 lanes, Q4.3 words.
module tb_folded_layer;

  localparam int N  = 2;
  localparam int NO = 4;
  localparam int L  = 2;
  localparam int W  = 8;
  localparam int F  = 3;

  logic              CLK = 1'b0;
  logic              RSTN;
  logic [N*W-1:0]    VALUES_IN;
  logic [NO*N*W-1:0] WEIGHTS_IN;
  logic [NO*W-1:0]   BIAS_IN;
  logic              VALID_IN;
  logic              READY_OUT;

  logic              ready_in_a, valid_out_a, ovf_a;
  logic [NO*W-1:0]   values_out_a;
  logic              ready_in_r, valid_out_r, ovf_r;
  logic [NO*W-1:0]   values_out_r;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  folded_layer #(.NUM_INPUTS(N), .NUM_OUTPUTS(NO), .NUM_LANES(L), .WIDTH(W),
                 .FRAC_BITS(F), .ACT_MODE(0)) dut (
    .CLK(CLK), .RSTN(RSTN), .VALUES_IN(VALUES_IN), .WEIGHTS_IN(WEIGHTS_IN),
    .BIAS_IN(BIAS_IN), .VALID_IN(VALID_IN), .READY_IN(ready_in_a),
    .VALUES_OUT(values_out_a), .VALID_OUT(valid_out_a), .READY_OUT(READY_OUT),
    .OVERFLOW_OUT(ovf_a)
  );

  folded_layer #(.NUM_INPUTS(N), .NUM_OUTPUTS(NO), .NUM_LANES(L), .WIDTH(W),
                 .FRAC_BITS(F), .ACT_MODE(1)) dut_relu (
    .CLK(CLK), .RSTN(RSTN), .VALUES_IN(VALUES_IN), .WEIGHTS_IN(WEIGHTS_IN),
    .BIAS_IN(BIAS_IN), .VALID_IN(VALID_IN), .READY_IN(ready_in_r),
    .VALUES_OUT(values_out_r), .VALID_OUT(valid_out_r), .READY_OUT(READY_OUT),
    .OVERFLOW_OUT(ovf_r)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NO*N*W-1:0] wts_all(input logic [W-1:0] w);
    logic [NO*N*W-1:0] v;
    for (int k = 0; k < NO*N; k++) v[k*W +: W] = w;
    return v;
  endfunction

  function automatic logic [NO*W-1:0] bias_all(input logic [W-1:0] b);
    logic [NO*W-1:0] v;
    for (int k = 0; k < NO; k++) v[k*W +: W] = b;
    return v;
  endfunction

  function automatic logic [NO*W-1:0] relu_vec(input logic [NO*W-1:0] x);
    logic [NO*W-1:0] v;
    v = x;
    for (int k = 0; k < NO; k++) if (x[k*W+W-1]) v[k*W +: W] = '0;
    return v;
  endfunction

  task automatic send(input string tag, input logic [N*W-1:0] vals,
                      input logic [NO*N*W-1:0] wts, input logic [NO*W-1:0] bias);
    VALUES_IN  = vals;
    WEIGHTS_IN = wts;
    BIAS_IN    = bias;
    VALID_IN   = 1'b1;
    check({tag, "_ready_in"}, 32'(ready_in_a), 32'd1);
    @(posedge CLK); #1;
    VALID_IN  = 1'b0;
    VALUES_IN = '0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!valid_out_a && cyc < 100) begin
      @(posedge CLK); #1;
      cyc++;
    end
    check({tag, "_valid_cycle"}, 32'(cyc + 1), 32'd7);
  endtask

  task automatic check_out(input string tag, input logic [NO*W-1:0] exp, input logic exp_ovf);
    check({tag, "_values"},      values_out_a, exp);
    check({tag, "_ovf"},         32'(ovf_a), 32'(exp_ovf));
    check({tag, "_relu_values"}, values_out_r, relu_vec(exp));
    check({tag, "_relu_ovf"},    32'(ovf_r), 32'(exp_ovf));
  endtask

  task automatic run(input string tag, input logic [N*W-1:0] vals,
                     input logic [NO*N*W-1:0] wts, input logic [NO*W-1:0] bias,
                     input logic [NO*W-1:0] exp, input logic exp_ovf);
    send(tag, vals, wts, bias);
    wait_done(tag);
    check_out(tag, exp, exp_ovf);
    @(posedge CLK); #1;
    check({tag, "_ready_back"}, {30'd0, ready_in_a, valid_out_a}, 32'b10);
  endtask

  initial begin
    RSTN       = 1'b0;
    VALID_IN   = 1'b0;
    READY_OUT  = 1'b1;
    VALUES_IN  = '0;
    WEIGHTS_IN = '0;
    BIAS_IN    = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ready_in",  32'(ready_in_a), 32'd1);
    check("rst_valid_out", 32'(valid_out_a), 32'd0);
    check("rst_values",    values_out_a, 32'd0);
    check("rst_ovf",       32'(ovf_a), 32'd0);
    RSTN = 1'b1;
    @(posedge CLK); #1;

    // 1.0*1.0 + 1.0*1.0 = 2.0
    run("nominal", {8'd8, 8'd8}, wts_all(8'd8), bias_all(8'd0), 32'h10101010, 1'b0);

    // in={1.0,2.0}; n0 w{1,1}=3.0, n1 w{2,-1}=0, n2 w{-1,0}=-1.0, n3 w{.5,.5}+b1.0=2.5
    run("mixed", {8'd16, 8'd8},
        {8'd4, 8'd4, 8'd0, 8'hF8, 8'hF8, 8'd16, 8'd8, 8'd8},
        {8'd8, 8'd0, 8'd0, 8'd0},
        {8'h14, 8'hF8, 8'h00, 8'h18}, 1'b0);

    run("sat_pos", {8'd64, 8'd64}, wts_all(8'd64), bias_all(8'd0), 32'h7F7F7F7F, 1'b1);
    run("sat_neg", {8'd64, 8'd64}, wts_all(8'hC0), bias_all(8'd0), 32'h80808080, 1'b1);

    // floor rounding of +/- 1/64
    run("floor_pos", {8'd0, 8'd1}, wts_all(8'd1),  bias_all(8'd0), 32'h00000000, 1'b0);
    run("floor_neg", {8'd0, 8'd1}, wts_all(8'hFF), bias_all(8'd0), 32'hFFFFFFFF, 1'b0);
    run("bias_only", {8'd0, 8'd0}, wts_all(8'd8),  bias_all(8'd8), 32'h08080808, 1'b0);

    run("neg_result", {8'd8, 8'd8}, wts_all(8'hF8), bias_all(8'd0), 32'hF0F0F0F0, 1'b0);

    // backpressure: DONE must hold for 10 cycles and ignore VALID_IN
    READY_OUT = 1'b0;
    send("bp", {8'd8, 8'd8}, wts_all(8'd8), bias_all(8'd0));
    wait_done("bp");
    for (int k = 0; k < 10; k++) begin
      VALID_IN  = k[0];
      VALUES_IN = 16'h2121;
      @(posedge CLK); #1;
      check("bp_hold_valid", {30'd0, valid_out_a, ready_in_a}, 32'b10);
      check("bp_hold_values", values_out_a, 32'h10101010);
    end
    READY_OUT = 1'b1;
    VALID_IN  = 1'b1;
    @(posedge CLK); #1;
    VALID_IN = 1'b0;
    check("bp_release", {30'd0, ready_in_a, valid_out_a}, 32'b10);
    check("bp_values_held", values_out_a, 32'h10101010);
    @(posedge CLK); #1;
    check("bp_no_accept", 32'(ready_in_a), 32'd1);

    // reset sampled at cycle 3 of an in-flight vector
    send("rst_mid", {8'd64, 8'd64}, wts_all(8'd64), bias_all(8'd0));
    @(posedge CLK); #1;
    RSTN = 1'b0;
    @(posedge CLK); #1;
    RSTN = 1'b1;
    check("rst_mid_valid",  32'(valid_out_a), 32'd0);
    check("rst_mid_values", values_out_a, 32'd0);
    check("rst_mid_ready",  32'(ready_in_a), 32'd1);
    check("rst_mid_ovf",    32'(ovf_a), 32'd0);
    run("after_rst", {8'd8, 8'd8}, wts_all(8'd8), bias_all(8'd0), 32'h10101010, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/folded_layer.md
# folded_layer

Time-multiplexed fully-connected layer: computes NUM_OUTPUTS neuron outputs from one input vector using only NUM_LANES physical multiply-accumulate lanes, iterating over output groups and inputs sequentially. Successor to the fully-parallel layer: adds folding, valid/ready handshakes on both sides, floor-rounded saturating fixed-point arithmetic, selectable activation and an overflow flag. Sits between consecutive layers in the network datapath; chains directly to another folded_layer.

## Interface
- NUM_INPUTS, 4: inputs per neuron (N), ≥1
- NUM_OUTPUTS, 4: neurons in layer, ≥1
- NUM_LANES, 2: parallel MAC lanes (L); NUM_OUTPUTS % NUM_LANES == 0, else elaboration error
- WIDTH, 8: signed fixed-point word width
- FRAC_BITS, 3: fractional bits, < WIDTH
- ACT_MODE, 0: 0 = identity, 1 = ReLU
- Derived: NUM_GROUPS G = NUM_OUTPUTS/NUM_LANES; ACC_W = 2*WIDTH + clog2(N) + 1

Ports (one clock; reset is synchronous and active-low):
- CLK  in  1  clock, all logic on rising edge
- RSTN  in  1  synchronous active-low reset
- VALUES_IN  in  N*WIDTH  signed input vector, element i at [i*WIDTH +: WIDTH]
- WEIGHTS_IN  in  NUM_OUTPUTS*N*WIDTH  weight for neuron o, input i at [(o*N+i)*WIDTH +: WIDTH]
- BIAS_IN  in  NUM_OUTPUTS*WIDTH  bias for neuron o at [o*WIDTH +: WIDTH]
- VALID_IN  in  1  input vector valid
- READY_IN  out  1  block can accept a vector
- VALUES_OUT  out  NUM_OUTPUTS*WIDTH  result vector, neuron o at [o*WIDTH +: WIDTH]
- VALID_OUT  out  1  result vector valid
- READY_OUT  in  1  downstream accepts result
- OVERFLOW_OUT  out  1  ≥1 neuron of current result saturated

## Operation
- FSM: IDLE, MAC, FINAL, DONE. Counters: input index i (0..N-1), group g (0..G-1).
- IDLE: READY_IN=1. On VALID_IN&READY_IN: latch VALUES_IN, clear accumulators, i=0, g=0, clear overflow, → MAC.
- MAC: lane l accumulates acc += VALUES[i] * W[g*L+l][i] (full-precision WIDTH×WIDTH product, 2*FRAC_BITS fractional bits). i==N-1 → FINAL, else i++.
- FINAL: per lane s = acc + (bias sign-extended << FRAC_BITS); r = s >>> FRAC_BITS (arithmetic, floor); saturate r to [-2^(WIDTH-1), 2^(WIDTH-1)-1], set overflow if clipped; ReLU (ACT_MODE=1) maps negative to 0 after saturation. Write to output slot g*L+l; clear acc, i=0. g==G-1 → DONE, else g++ → MAC.
- DONE: VALID_OUT=1, VALUES_OUT/OVERFLOW_OUT stable. On READY_OUT → IDLE.
- VALUES_IN sampled only at handshake. WEIGHTS_IN, BIAS_IN read live; must be stable from handshake to VALID_OUT (caller's responsibility).
- READY_IN=0 in MAC/FINAL/DONE; VALID_IN ignored there, including the DONE→IDLE cycle (no same-cycle accept).
- VALUES_OUT holds last result after leaving DONE until overwritten by next FINAL writes.

## Timing
- Reset (RSTN=0 at edge): state IDLE, READY_IN=1 after reset, VALID_OUT=0, VALUES_OUT=0, OVERFLOW_OUT=0, counters and accumulators 0. Applies mid-operation; in-flight vector discarded.
- Handshake edge = cycle 0. MAC for group g occupies cycles g*(N+1)+1 .. g*(N+1)+N; FINAL at (g+1)*(N+1).
- VALID_OUT first high in cycle G*(N+1)+1. Throughput: one vector per G*(N+1)+2 cycles minimum (DONE + IDLE).
- VALID_OUT, once high, stays high with constant data until READY_OUT sampled high.
- All outputs registered; no combinational path input→output.

## Structure
- Package folded_layer_pkg: ACT_NONE=0, ACT_RELU=1 constants; sat function (ACC_W→WIDTH clip with overflow flag).
- Sub-module mac_lane: one accumulator, clear/enable, finalize (bias, shift, saturate, activation); instantiated NUM_LANES times. FSM, counters, weight/bias mux and output registers in folded_layer.

## Test plan
(WIDTH=8, FRAC_BITS=3, N=2, NUM_OUTPUTS=4, L=2 ⇒ G=2; 1.0 = 8)
- Nominal: inputs {8,8}, all weights 8, biases 0, READY_OUT=1 -> VALID_OUT in cycle 7, all outputs 16, OVERFLOW_OUT=0, READY_IN back high cycle 8.
- Saturation: inputs {64,64}, weights 64 -> outputs 127, OVERFLOW_OUT=1; weights -64 -> outputs -128, OVERFLOW_OUT=1.
- Rounding/bias: inputs {1,0}, weight 1 -> 0; weight -1 -> -1; bias 8 with inputs 0 -> 8.
- ReLU (ACT_MODE=1): inputs {8,8}, weights -8 -> outputs 0; weights 8 -> 16.
- Backpressure: hold READY_OUT=0 for 10 cycles in DONE, toggle VALID_IN -> VALID_OUT, VALUES_OUT constant, READY_IN=0, no second accept; release -> IDLE next cycle.
- Reset mid-MAC: RSTN=0 at cycle 3 -> next cycle VALID_OUT=0, VALUES_OUT=0, READY_IN=1; new vector then completes normally with correct values.
